// File: rtl/ru_loader.sv
// ---------------------------------------------------------------------------
// ru_loader
//   Boot-time register-file loader for the single-cycle RISC-V core. Takes a
//   byte stream over valid/ready and assembles little-endian 32-bit words.
//   Each finished word is written to x1..xLAST_REG, in order, through the
//   register unit's write port. While a load is running, busy stalls the
//   core.
//
// Ports
//   CLK       in   1   system clock, rising edge
//   RST       in   1   synchronous active-high reset
//   start     in   1   begin a load (honoured only in IDLE)
//   in_data   in   8   stream byte
//   in_valid  in   1   in_data is valid
//   in_ready  out  1   loader accepts a byte this cycle
//   rd        out  5   destination register (non-zero only while writing)
//   DataWr    out  32  write data (non-zero only while writing)
//   RUWr      out  1   register-unit write enable
//   busy      out  1   load in progress, core must stall
//   done      out  1   one-cycle pulse after the last register is written
// ---------------------------------------------------------------------------
module ru_loader #(
  parameter int unsigned LAST_REG = 31
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [4:0]  rd,
  output logic [31:0] DataWr,
  output logic        RUWr,
  output logic        busy,
  output logic        done
);

  localparam int unsigned IdxW  = 5;
  localparam int unsigned CntW  = 2;
  localparam int unsigned WordW = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    reg_idx_q, reg_idx_d;
  logic [CntW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [WordW-1:0]   word_q, word_d;

  // Outputs are registered from the next state, so each one is a clean
  // function of the state the FSM is in during that cycle.
  logic               in_ready_q, in_ready_d;
  logic [IdxW-1:0]    rd_q, rd_d;
  logic [WordW-1:0]   data_wr_q, data_wr_d;
  logic               ru_wr_q, ru_wr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept;
  logic               last_reg;

  // A byte is consumed only while collecting. in_ready_q is asserted
  // exactly in COLLECT, so this is the valid&ready handshake.
  assign accept   = (state_q == S_COLLECT) && in_valid;
  assign last_reg = (reg_idx_q == IdxW'(LAST_REG));

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d    = state_q;
    reg_idx_d  = reg_idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_COLLECT;
          reg_idx_d  = IdxW'(1);
          byte_cnt_d = '0;
          word_d     = '0;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          // The word is cleared at the start of every word, so OR-ing the
          // byte into its little-endian slot fills the slot.
          word_d     = word_q | (WordW'(in_data) << {byte_cnt_q, 3'b000});
          byte_cnt_d = byte_cnt_q + CntW'(1);
          if (byte_cnt_q == CntW'(3)) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (last_reg) begin
          state_d = S_DONE;
        end else begin
          state_d    = S_COLLECT;
          reg_idx_d  = reg_idx_q + IdxW'(1);
          byte_cnt_d = '0;
          word_d     = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_COLLECT);
    ru_wr_d    = (state_d == S_WRITE);
    rd_d       = (state_d == S_WRITE) ? reg_idx_d : '0;
    data_wr_d  = (state_d == S_WRITE) ? word_d : '0;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  // State and output registers. Reset wins over start on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      reg_idx_q  <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      in_ready_q <= 1'b0;
      rd_q       <= '0;
      data_wr_q  <= '0;
      ru_wr_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_idx_q  <= reg_idx_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      in_ready_q <= in_ready_d;
      rd_q       <= rd_d;
      data_wr_q  <= data_wr_d;
      ru_wr_q    <= ru_wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign rd       = rd_q;
  assign DataWr   = data_wr_q;
  assign RUWr     = ru_wr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
